ntt_psi_premul_loader: RTL and testbench



---
 rtl/ntt_psi_premul_loader.sv | 134 +++++++++++++
 tb/tb_ntt_psi_premul_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_psi_premul_loader.sv
// Serial-in psi pre-multiplier for the radix-8 NTT butterfly: weights eight coefficients by psi[k] mod Q
// through a two-stage pipeline and presents the weighted frame in parallel under valid/ready.
module ntt_psi_premul_loader #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [8*WIDTH-1:0]   psi_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic                 range_err
);

    localparam logic [WIDTH-1:0]   Q_N = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] Q_W = {{WIDTH{1'b0}}, Q_N};

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t             state;
    logic [2:0]         idx;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               accept;
    logic [WIDTH-1:0]   psi_sel;

    logic [2*WIDTH-1:0] prod_p1;
    logic [2:0]         idx_p1;
    logic               vld_p1;

    logic [WIDTH-1:0]   slot_q [8];

    function automatic logic [WIDTH-1:0] mod_q(input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] r;
        r = p % Q_W;
        return r[WIDTH-1:0];
    endfunction

    // clear overrides the registered ready so an aborting cycle never transfers a beat
    assign in_ready  = in_ready_r && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_r;

    always_comb begin
        psi_sel = '0;
        for (int k = 0; k < 8; k++) begin
            if (idx == 3'(k)) psi_sel = psi_bus[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) begin
            out_data[k*WIDTH +: WIDTH] = slot_q[k];
        end
    end

    // Stage 0 -> 1: raw product of the accepted beat and its weight
    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1 <= {{WIDTH{1'b0}}, in_data} * {{WIDTH{1'b0}}, psi_sel};
            idx_p1  <= idx;
        end
    end

    // Stage 1 -> 2: modular reduction straight into the frame buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) slot_q[k] <= '0;
        end else if (vld_p1 && !clear) begin
            slot_q[idx_p1] <= mod_q(prod_p1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= 3'd0;
            vld_p1      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept && (in_data >= Q_N || psi_sel >= Q_N)) range_err <= 1'b1;
            if (clear) begin
                state       <= FILL;
                idx         <= 3'd0;
                vld_p1      <= 1'b0;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
            end else begin
                case (state)
                    FILL: begin
                        if (accept) begin
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                state      <= DRAIN;
                                in_ready_r <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        // the last slot lands in the buffer this cycle, so the frame is complete next cycle
                        if (vld_p1 && idx_p1 == 3'd7) begin
                            state       <= HOLD;
                            out_valid_r <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state       <= FILL;
                            idx         <= 3'd0;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= FILL;
                        idx         <= 3'd0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ntt_psi_premul_loader.sv
// Bench for ntt_psi_premul_loader: random frames checked against a plain mod-Q reference and
// handshake timing rules.
module tb_ntt_psi_premul_loader;
    localparam int WIDTH = 18;
    localparam int Q     = 12289;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic [8*WIDTH-1:0]   psi_bus = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 range_err;
    logic [8*WIDTH-1:0]   out_data;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] fd [8];
    logic [WIDTH-1:0] fp [8];
    logic [WIDTH-1:0] exp_s [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_psi_premul_loader #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .psi_bus(psi_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .range_err(range_err)
    );

    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] p);
        longint r;
        r = (longint'(x) * longint'(p)) % longint'(Q);
        return WIDTH'(r);
    endfunction

    function automatic logic [WIDTH-1:0] slot(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic build_expected();
        for (int k = 0; k < 8; k++) exp_s[k] = golden(fd[k], fp[k]);
    endtask

    task automatic random_frame();
        for (int k = 0; k < 8; k++) begin
            fd[k] = WIDTH'($urandom_range(0, Q - 1));
            fp[k] = WIDTH'($urandom_range(0, Q - 1));
        end
        build_expected();
    endtask

    // Offers fd[] beats (with an optional in_valid duty pattern) until nbeats transfer.
    task automatic send_frame(input int nbeats, input int gap, input bit keep_valid,
                              output int first_c, output int last_c, output bit ok);
        int n = 0;
        int step = 0;
        ok = 1'b1; first_c = -1; last_c = -1;
        for (int k = 0; k < 8; k++) psi_bus[k*WIDTH +: WIDTH] = fp[k];
        while (n < nbeats) begin
            in_valid = (gap == 0) || (step % (gap + 1) == 0);
            in_data  = fd[n];
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (n == 0) first_c = cyc;
                last_c = cyc;
                n++;
            end
            step++;
            @(posedge clk); #1;
            if (step > 200) begin ok = 1'b0; break; end
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Returns at the falling edge of the first cycle showing out_valid.
    task automatic wait_out(output int seen_c, output bit ok);
        seen_c = -1; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin seen_c = cyc; ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'($urandom); clear = 1'($urandom); out_ready = 1'($urandom);
            in_data = WIDTH'($urandom);
            for (int k = 0; k < 8; k++) psi_bus[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) $display("FAIL reset_hold_out_valid: got %b want 0", out_valid);
            else passed++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
        total++;
        if (range_err !== 1'b0) $display("FAIL reset_range_err: got %b want 0", range_err); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_unit_psi();
        int f, l, s;
        bit ok, ok2;
        for (int k = 0; k < 8; k++) begin fd[k] = WIDTH'(k + 1); fp[k] = WIDTH'(1); end
        build_expected();
        out_ready = 1'b1;
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        total++;
        if (!(ok && ok2 && s == l + 2))
            $display("FAIL unit_latency: out_valid at cycle %0d want %0d (ok=%b/%b)", s, l + 2, ok, ok2);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (slot(k) !== WIDTH'(k + 1) || slot(k) !== exp_s[k])
                $display("FAIL unit_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL unit_after_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_neg_one_and_range();
        int f, l, s;
        bit ok, ok2;
        for (int k = 0; k < 8; k++) begin fd[k] = WIDTH'(k + 1); fp[k] = WIDTH'(Q - 1); end
        build_expected();
        out_ready = 1'b1;
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== WIDTH'(Q - 1 - k))
                $display("FAIL neg1_slot%0d: got %0d want %0d", k, slot(k), Q - 1 - k);
            else passed++;
        end
        total++;
        if (range_err !== 1'b0) $display("FAIL neg1_range_err: got %b want 0", range_err); else passed++;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin fd[k] = WIDTH'(Q - 1); fp[k] = WIDTH'(131071); end
        build_expected();
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL bigpsi_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        total++;
        if (range_err !== 1'b1) $display("FAIL bigpsi_range_err: got %b want 1", range_err); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int f, l, s, hs_c;
        bit ok, ok2;
        logic [8*WIDTH-1:0] held;
        random_frame();
        out_ready = 1'b0;
        send_frame(8, 0, 1'b1, f, l, ok);
        wait_out(s, ok2);
        held = out_data;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL bp_frameA_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
                $display("FAIL bp_stall_c%0d: in_ready=%b out_valid=%b data_changed=%b want 0/1/0",
                         c, in_ready, out_valid, out_data !== held);
            else passed++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        hs_c = cyc;
        total++;
        if (out_valid !== 1'b1) $display("FAIL bp_handshake: out_valid=%b want 1", out_valid); else passed++;
        @(posedge clk); #1;
        random_frame();
        send_frame(8, 0, 1'b0, f, l, ok);
        total++;
        if (!ok || f != hs_c + 1)
            $display("FAIL bp_first_beat: accepted at cycle %0d want %0d", f, hs_c + 1);
        else passed++;
        wait_out(s, ok2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL bp_frameB_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        int f, l, s;
        bit ok, ok2;
        random_frame();
        out_ready = 1'b1;
        send_frame(8, 2, 1'b0, f, l, ok);
        wait_out(s, ok2);
        total++;
        if (!(ok && ok2 && s == l + 2))
            $display("FAIL gaps_latency: out_valid at cycle %0d want %0d", s, l + 2);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL gaps_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int f, l, s;
        bit ok, ok2;
        random_frame();
        out_ready = 1'b1;
        send_frame(5, 0, 1'b0, f, l, ok);
        clear = 1'b1; in_valid = 1'b1; in_data = fd[5];
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL clear_blocks_ready: got %b want 0", in_ready); else passed++;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) $display("FAIL clear_no_out: got %b want 0", out_valid); else passed++;
            @(posedge clk); #1;
        end
        random_frame();
        out_ready = 1'b0;
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL clear_new_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
        clear = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL clear_with_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else passed++;
        @(posedge clk); #1;
        random_frame();
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL clear_next_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_drain();
        int f, l, s;
        bit ok, ok2;
        random_frame();
        out_ready = 1'b1;
        send_frame(8, 0, 1'b0, f, l, ok);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || range_err !== 1'b0)
            $display("FAIL drain_reset: in_ready=%b out_valid=%b out_data=%h range_err=%b want 1/0/0/0",
                     in_ready, out_valid, out_data, range_err);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) $display("FAIL drain_reset_no_out: got %b want 0", out_valid); else passed++;
            @(posedge clk); #1;
        end
        random_frame();
        send_frame(8, 0, 1'b0, f, l, ok);
        wait_out(s, ok2);
        total++;
        if (!(ok && ok2 && s == l + 2))
            $display("FAIL drain_clean_latency: out_valid at cycle %0d want %0d", s, l + 2);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (!ok2 || slot(k) !== exp_s[k])
                $display("FAIL drain_clean_slot%0d: got %0d want %0d", k, slot(k), exp_s[k]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unit_psi();
        test_neg_one_and_range();
        test_backpressure();
        test_gaps();
        test_clear();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
